// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access size codes,
// default memory depth and the alignment rule used at request acceptance.
package load_store_unit_pkg;

    // Controller states; reqReady is only offered in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } lsu_state_e;

    // Access size codes carried on reqSize.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Default number of 32-bit words in the attached data memory.
    localparam int MEM_WORDS_DEFAULT = 128;

    // True when the byte offset is illegal for the size; the reserved size is
    // always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational little-endian lane handling: extracts and extends a loaded
// byte/half/word, and merges store data into the addressed lane(s) of a word.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_placed;

    // Select the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        w_shifted   = i_mem_word >> {i_lane, 3'b000};
        w_byte      = w_shifted[7:0];
        w_half      = i_lane[1] ? i_mem_word[31:16] : i_mem_word[15:0];
        o_load_data = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_load_data = i_mem_word;
            default: o_load_data = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lane(s) of the old word with store data.
    always_comb begin
        w_mask   = 32'h0000_0000;
        w_placed = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: begin
                w_mask   = 32'h0000_00FF << {i_lane, 3'b000};
                w_placed = {24'h00_0000, i_store_data[7:0]} << {i_lane, 3'b000};
            end
            SZ_HALF: begin
                w_mask   = 32'h0000_FFFF << {i_lane[1], 4'b0000};
                w_placed = {16'h0000, i_store_data[15:0]} << {i_lane[1], 4'b0000};
            end
            SZ_WORD: begin
                w_mask   = 32'hFFFF_FFFF;
                w_placed = i_store_data;
            end
            default: begin
                w_mask   = 32'h0000_0000;
                w_placed = 32'h0000_0000;
            end
        endcase
        o_merge_data = (i_mem_word & ~w_mask) | (w_placed & w_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request/response handshake and a single-port
// word memory with combinational read data. Sub-word stores are done as
// read-modify-write; illegal accesses answer with an error and no strobe.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
)
(
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAdress,
    input  logic [31:0] reqData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respError,
    output logic [31:0] adress,
    output logic [31:0] writeData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] dataMemory
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;

    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic [31:0] r_store_data;
    logic [31:0] r_adress;
    logic [31:0] r_write_data;
    logic [31:0] r_resp_data;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_req_err;
    logic        w_word_store;
    logic [31:0] w_index;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    // Request classification, evaluated on the live request fields.
    assign w_accept       = reqValid & (r_state == IDLE);
    assign w_misaligned   = is_misaligned(reqSize, reqAdress[1:0]);
    assign w_out_of_range = ({2'b00, reqAdress[31:2]} >= 32'($unsigned(MEM_WORDS)));
    assign w_req_err      = w_misaligned | w_out_of_range;
    assign w_word_store   = reqWrite & (reqSize == SZ_WORD);
    assign w_index        = {{(32-AW){1'b0}}, reqAdress[AW+1:2]};

    lsu_lane_align u_lane_align (
        .i_mem_word   (dataMemory),
        .i_store_data (r_store_data),
        .i_lane       (r_lane),
        .i_size       (r_size),
        .i_signed     (r_signed),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (reqValid) begin
                    if (w_req_err) begin
                        w_state_next = RSP;
                    end else if (w_word_store) begin
                        w_state_next = WR;
                    end else begin
                        w_state_next = RD;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            RD: begin
                if (r_write) begin
                    w_state_next = WR;
                end else begin
                    w_state_next = RSP;
                end
            end
            WR: w_state_next = RSP;
            RSP: begin
                if (respReady) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = RSP;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake and strobe decode straight from the state register, so the
    // strobes drop the moment reset forces IDLE.
    always_comb begin
        reqReady  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        respValid = 1'b0;
        case (r_state)
            IDLE:    reqReady  = 1'b1;
            RD:      MemRead   = 1'b1;
            WR:      MemWrite  = 1'b1;
            RSP:     respValid = 1'b1;
            default: reqReady  = 1'b0;
        endcase
    end

    // Request capture, read-data capture and response hold.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_lane       <= 2'b00;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_write      <= 1'b0;
            r_store_data <= 32'h0000_0000;
            r_adress     <= 32'h0000_0000;
            r_write_data <= 32'h0000_0000;
            r_resp_data  <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lane       <= reqAdress[1:0];
                        r_size       <= reqSize;
                        r_signed     <= reqSigned;
                        r_write      <= reqWrite;
                        r_store_data <= reqData;
                        r_adress     <= w_req_err ? 32'h0000_0000 : w_index;
                        r_write_data <= (w_word_store && !w_req_err) ? reqData : 32'h0000_0000;
                        r_resp_data  <= 32'h0000_0000;
                        r_resp_err   <= w_req_err;
                    end
                end
                RD: begin
                    // Stores merge into the old word; loads extract their lane.
                    if (r_write) begin
                        r_write_data <= w_merge_data;
                    end else begin
                        r_resp_data  <= w_load_data;
                    end
                end
                WR: begin
                    r_resp_data <= 32'h0000_0000;
                end
                RSP: begin
                    r_resp_err <= r_resp_err;
                end
                default: begin
                    r_resp_err <= 1'b0;
                end
            endcase
        end
    end

    assign adress    = r_adress;
    assign writeData = r_write_data;
    assign respData  = r_resp_data;
    assign respError = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 128-word memory.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqSigned = 1'b0;
    logic [31:0] reqAdress = 32'h0;
    logic [31:0] reqData = 32'h0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [31:0] respData;
    logic        respError;
    logic [31:0] adress;
    logic [31:0] writeData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] dataMemory;

    logic [31:0] mem [0:127];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_wr_adr = 32'h0;

    int n_total = 0;
    int n_pass  = 0;

    load_store_unit #(.MEM_WORDS(128)) dut (
        .clock(clock), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAdress(reqAdress),
        .reqData(reqData), .respValid(respValid), .respReady(respReady),
        .respData(respData), .respError(respError), .adress(adress),
        .writeData(writeData), .MemWrite(MemWrite), .MemRead(MemRead),
        .dataMemory(dataMemory)
    );

    always #5 clock = ~clock;

    assign dataMemory = mem[adress[6:0]];

    // Memory model and strobe counters.
    always @(posedge clock) begin
        if (MemWrite) begin
            mem[adress[6:0]] <= writeData;
            wr_cnt           <= wr_cnt + 1;
            last_wr_adr      <= adress;
        end
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One complete access: returns response data/error and cycles from acceptance to respValid.
    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clock);
        reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg;
        reqAdress = addr; reqData = wd;
        check("req_ready_idle", {31'b0, reqReady}, 32'd1);
        @(posedge clock);
        #1 reqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!respValid && lat < 20);
        check("resp_valid_seen", {31'b0, respValid}, 32'd1);
        rd = respData;
        er = respError;
        respReady = 1'b1;
        @(posedge clock);
        #1 respReady = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          w0, r0;

        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          w0, r0;
        logic [31:0] held;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_reqReady",  {31'b0, reqReady},  32'd1);
        check("rst_respValid", {31'b0, respValid}, 32'd0);
        check("rst_respError", {31'b0, respError}, 32'd0);
        check("rst_respData",  respData,  32'h0);
        check("rst_adress",    adress,    32'h0);
        check("rst_writeData", writeData, 32'h0);
        check("rst_strobes",   {30'b0, MemRead, MemWrite}, 32'd0);
        resetN = 1'b1;

        // Word store then word load at 0x10
        w0 = wr_cnt; r0 = rd_cnt;
        access(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, d, e, lat);
        check("ws_wr_once",  32'(wr_cnt - w0), 32'd1);
        check("ws_no_read",  32'(rd_cnt - r0), 32'd0);
        check("ws_adress",   last_wr_adr, 32'd4);
        check("ws_mem",      mem[4], 32'hDEADBEEF);
        check("ws_data0",    d, 32'h0);
        check("ws_err",      {31'b0, e}, 32'd0);
        check("ws_lat",      32'(lat), 32'd2);
        r0 = rd_cnt;
        access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, d, e, lat);
        check("wl_data",     d, 32'hDEADBEEF);
        check("wl_lat",      32'(lat), 32'd2);
        check("wl_read_once", 32'(rd_cnt - r0), 32'd1);

        // Byte RMW store into 0x11223344, then signed/unsigned byte loads
        access(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, d, e, lat);
        w0 = wr_cnt; r0 = rd_cnt;
        access(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h00000080, d, e, lat);
        check("bs_mem",      mem[4], 32'h80223344);
        check("bs_lat",      32'(lat), 32'd3);
        check("bs_rd_wr",    32'((wr_cnt - w0) * 16 + (rd_cnt - r0)), 32'h11);
        access(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, d, e, lat);
        check("lb_signed",   d, 32'hFFFFFF80);
        access(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, d, e, lat);
        check("lb_unsigned", d, 32'h00000080);

        // Halfword lanes and half store
        access(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h80017F02, d, e, lat);
        access(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, d, e, lat);
        check("lh_signed_hi",   d, 32'hFFFF8001);
        access(1'b0, SZ_HALF, 1'b0, 32'h14, 32'h0, d, e, lat);
        check("lh_unsigned_lo", d, 32'h00007F02);
        access(1'b0, SZ_BYTE, 1'b1, 32'h15, 32'h0, d, e, lat);
        check("lb_signed_pos",  d, 32'h0000007F);
        access(1'b1, SZ_HALF, 1'b0, 32'h16, 32'h1234ABCD, d, e, lat);
        check("sh_mem",         mem[5], 32'hABCD7F02);
        access(1'b0, SZ_BYTE, 1'b0, 32'h17, 32'h0, d, e, lat);
        check("lb_lane3",       d, 32'h000000AB);

        // Last legal word
        access(1'b1, SZ_WORD, 1'b0, 32'h1FC, 32'h0BADF00D, d, e, lat);
        access(1'b0, SZ_WORD, 1'b0, 32'h1FC, 32'h0, d, e, lat);
        check("top_word",  d, 32'h0BADF00D);
        check("top_err",   {31'b0, e}, 32'd0);

        // Rejected accesses: no strobes, error response one cycle after acceptance
        w0 = wr_cnt; r0 = rd_cnt;
        access(1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0, d, e, lat);
        check("mis_half_err",  {31'b0, e}, 32'd1);
        check("mis_half_data", d, 32'h0);
        check("mis_half_lat",  32'(lat), 32'd1);
        access(1'b1, SZ_WORD, 1'b0, 32'h200, 32'hFFFFFFFF, d, e, lat);
        check("oor_store_err", {31'b0, e}, 32'd1);
        check("oor_store_data", d, 32'h0);
        access(1'b0, SZ_RSVD, 1'b0, 32'h0, 32'h0, d, e, lat);
        check("rsvd_err",      {31'b0, e}, 32'd1);
        access(1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0, d, e, lat);
        check("mis_word_err",  {31'b0, e}, 32'd1);
        check("err_no_strobe", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

        // Response held while respReady stays low
        @(negedge clock);
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = SZ_WORD; reqAdress = 32'h10;
        @(posedge clock);
        #1 reqValid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        held = respData;
        check("hold_data", held, 32'h80223344);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, respValid}, 32'd1);
            check("hold_stable", respData, 32'h80223344);
            check("hold_reqReady", {31'b0, reqReady}, 32'd0);
            @(negedge clock);
        end
        respReady = 1'b1;
        @(posedge clock);
        #1 respReady = 1'b0;
        @(negedge clock);
        check("hold_release_valid", {31'b0, respValid}, 32'd0);
        check("hold_release_ready", {31'b0, reqReady}, 32'd1);

        // Reset during the read phase of a byte store
        access(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h55555555, d, e, lat);
        w0 = wr_cnt;
        @(negedge clock);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = SZ_BYTE; reqAdress = 32'h31; reqData = 32'hAA;
        @(posedge clock);
        #1 reqValid = 1'b0;
        check("abort_rd_active", {31'b0, MemRead}, 32'd1);
        #2 resetN = 1'b0;
        #1;
        check("abort_rd_drop",  {31'b0, MemRead},  32'd0);
        check("abort_no_wr",    {31'b0, MemWrite}, 32'd0);
        check("abort_ready",    {31'b0, reqReady}, 32'd1);
        @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_wr_cnt",   32'(wr_cnt - w0), 32'd0);
        check("abort_mem",      mem[12], 32'h55555555);
        check("abort_no_resp",  {31'b0, respValid}, 32'd0);
        check("abort_idle",     {31'b0, reqReady}, 32'd1);
        access(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, d, e, lat);
        check("post_reset_load", d, 32'h55555555);

        check("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
